// File: rtl/axis_loopback_fifo_if.sv
// AXI4-Stream beat bundle shared by the loopback FIFO's input and output sides.
// The master drives the payload and tvalid. The slave drives tready.
interface axis_loopback_fifo_if #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_loopback_fifo.sv
// First-word-fall-through AXI4-Stream FIFO between the MM2S and S2MM DMA streams.
// It keeps delivered-packet and delivered-byte statistics that can be cleared.
module axis_loopback_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rstn,
    axis_loopback_fifo_if.slave         s_axis,
    axis_loopback_fifo_if.master        m_axis,
    input  logic                        clear,
    output logic [PTR_WIDTH:0]          level,
    output logic [31:0]                 pkt_count,
    output logic [31:0]                 byte_count
);
    localparam int                   ENTRY_W  = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PTR_WIDTH:0]   LVL_FULL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   LVL_ONE  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + {31'd0, keep[i]};
        end
        return cnt;
    endfunction

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [PTR_WIDTH:0]   r_level;
    logic                 r_s_ready;
    logic [31:0]          r_pkt_count;
    logic [31:0]          r_byte_count;

    logic [PTR_WIDTH:0]   w_level_nxt;
    logic                 w_m_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_head;

    assign w_m_valid = (r_level != '0);
    assign w_push    = s_axis.tvalid && r_s_ready;
    assign w_pop     = w_m_valid && m_axis.tready;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // tready is precomputed from the next occupancy, so it never sees m_axis.tready combinationally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level   <= w_level_nxt;
            r_s_ready <= (w_level_nxt != LVL_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
    end

    // Clear has priority over a delivery in the same cycle, so that beat is not counted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
        end else if (clear) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
        end else if (w_pop) begin
            r_pkt_count  <= r_pkt_count + {31'd0, w_head[0]};
            r_byte_count <= r_byte_count + popcount(w_head[KEEP_WIDTH:1]);
        end
    end

    assign s_axis.tready = r_s_ready;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = w_head[ENTRY_W-1:KEEP_WIDTH+1];
    assign m_axis.tkeep  = w_head[KEEP_WIDTH:1];
    assign m_axis.tlast  = w_head[0];
    assign level         = r_level;
    assign pkt_count     = r_pkt_count;
    assign byte_count    = r_byte_count;
endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Directed bench for axis_loopback_fifo: a cycle vector table plus hand sequences
// for fill and backpressure, streaming, and mid-packet asynchronous reset.
module tb_axis_loopback_fifo;
    logic        clk;
    logic        rstn;
    logic        clear;
    logic [4:0]  level;
    logic [31:0] pkt_count;
    logic [31:0] byte_count;

    int n_pass  = 0;
    int n_total = 0;

    axis_loopback_fifo_if #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) s_if ();
    axis_loopback_fifo_if #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) m_if ();

    axis_loopback_fifo #(.DATA_WIDTH(128), .KEEP_WIDTH(16), .DEPTH(16), .PTR_WIDTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .clear      (clear),
        .level      (level),
        .pkt_count  (pkt_count),
        .byte_count (byte_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000 ns");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic         s_valid;
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         m_ready;
        logic         clr;
        logic [4:0]   e_level;
        logic         e_mvalid;
        logic         e_sready;
        logic [31:0]  e_pkt;
        logic [31:0]  e_byte;
        logic [127:0] e_data;
        logic [15:0]  e_keep;
        logic         e_last;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] D1, DA, DB, DC, DE, DF;
    logic [144:0] q[$];
    logic [144:0] exp_beat;
    logic [127:0] rd;
    logic [15:0]  rk;
    logic         rl;
    int           n_pop;
    int           max_lvl;
    logic [31:0]  exp_pkt;
    logic [31:0]  exp_byte;
    int           stale;

    initial begin
        D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        DA = 128'hA0A0_0000_0000_0000_0000_0000_0000_0001;
        DB = 128'hB0B0_0000_0000_0000_0000_0000_0000_0002;
        DC = 128'hC0C0_0000_0000_0000_0000_0000_0000_0003;
        DE = 128'hE0E0_0000_0000_0000_0000_0000_0000_0004;
        DF = 128'hF0F0_0000_0000_0000_0000_0000_0000_0005;
        //          sv    data    keep       last  mrdy  clr   lvl   mv    sr    pkt    byte    e_data  e_keep     e_last
        vecs[0]  = '{1'b1, D1,     16'hFFFF,  1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'd0, 32'd0,  D1,     16'hFFFF,  1'b1};
        vecs[1]  = '{1'b0, '0,     16'h0,     1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'd1, 32'd16, '0,     16'h0,     1'b0};
        vecs[2]  = '{1'b0, '0,     16'h0,     1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0,  '0,     16'h0,     1'b0};
        vecs[3]  = '{1'b1, DA,     16'hFFFF,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'd0, 32'd0,  DA,     16'hFFFF,  1'b0};
        vecs[4]  = '{1'b1, DB,     16'hFFFF,  1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 32'd0, 32'd16, DB,     16'hFFFF,  1'b0};
        vecs[5]  = '{1'b1, DC,     16'h000F,  1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 32'd0, 32'd32, DC,     16'h000F,  1'b1};
        vecs[6]  = '{1'b0, '0,     16'h0,     1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'd1, 32'd36, '0,     16'h0,     1'b0};
        vecs[7]  = '{1'b1, DE,     16'h00FF,  1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'd1, 32'd36, DE,     16'h00FF,  1'b1};
        vecs[8]  = '{1'b1, DF,     16'h0003,  1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 32'd1, 32'd36, DE,     16'h00FF,  1'b1};
        vecs[9]  = '{1'b0, '0,     16'h0,     1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 32'd0, 32'd0,  DF,     16'h0003,  1'b1};
        vecs[10] = '{1'b0, '0,     16'h0,     1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'd1, 32'd2,  '0,     16'h0,     1'b0};

        rstn = 1'b0;
        clear = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b0;

        // Outputs while held in reset
        #12;
        chk("rst_sready", 160'(s_if.tready), 160'(0));
        chk("rst_mvalid", 160'(m_if.tvalid), 160'(0));
        chk("rst_level", 160'(level), 160'(0));
        chk("rst_pkt", 160'(pkt_count), 160'(0));
        chk("rst_byte", 160'(byte_count), 160'(0));
        #10 rstn = 1'b1;
        step();
        chk("rel_sready", 160'(s_if.tready), 160'(1));

        for (int i = 0; i < 11; i++) begin
            s_if.tvalid = vecs[i].s_valid;
            s_if.tdata  = vecs[i].data;
            s_if.tkeep  = vecs[i].keep;
            s_if.tlast  = vecs[i].last;
            m_if.tready = vecs[i].m_ready;
            clear       = vecs[i].clr;
            step();
            chk($sformatf("v%0d_level", i), 160'(level), 160'(vecs[i].e_level));
            chk($sformatf("v%0d_mvalid", i), 160'(m_if.tvalid), 160'(vecs[i].e_mvalid));
            chk($sformatf("v%0d_sready", i), 160'(s_if.tready), 160'(vecs[i].e_sready));
            chk($sformatf("v%0d_pkt", i), 160'(pkt_count), 160'(vecs[i].e_pkt));
            chk($sformatf("v%0d_byte", i), 160'(byte_count), 160'(vecs[i].e_byte));
            if (vecs[i].e_mvalid)
                chk($sformatf("v%0d_payload", i), 160'({m_if.tdata, m_if.tkeep, m_if.tlast}),
                    160'({vecs[i].e_data, vecs[i].e_keep, vecs[i].e_last}));
        end
        clear = 1'b0;

        // Fill to DEPTH under backpressure, then try an overflow write
        m_if.tready = 1'b0;
        s_if.tkeep = '0;
        s_if.tlast = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata = 128'(i);
            step();
        end
        chk("fill_level", 160'(level), 160'(16));
        chk("fill_sready", 160'(s_if.tready), 160'(0));
        s_if.tdata = 128'hDEAD;
        step();
        chk("over_level", 160'(level), 160'(16));
        m_if.tready = 1'b1;
        step();
        chk("pop_full_level", 160'(level), 160'(15));
        chk("pop_full_sready", 160'(s_if.tready), 160'(1));
        s_if.tvalid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain%0d", i), 160'(m_if.tdata), 160'(i));
            step();
        end
        chk("drain_level", 160'(level), 160'(0));
        chk("drain_mvalid", 160'(m_if.tvalid), 160'(0));

        // Back-to-back streaming with both sides ready
        m_if.tready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_if.tready = 1'b1;
        n_pop = 0;
        max_lvl = 0;
        exp_pkt = '0;
        exp_byte = '0;
        for (int c = 0; c <= 100; c++) begin
            s_if.tvalid = (c < 100);
            if (c < 100) begin
                rd = {$urandom, $urandom, $urandom, $urandom};
                rk = 16'($urandom);
                rl = 1'($urandom_range(0, 1));
                s_if.tdata = rd;
                s_if.tkeep = rk;
                s_if.tlast = rl;
            end
            if (m_if.tvalid && m_if.tready) begin
                n_pop++;
                if (q.size() == 0) begin
                    chk("stream_extra_beat", 160'(1), 160'(0));
                end else begin
                    exp_beat = q.pop_front();
                    chk($sformatf("stream_beat%0d", n_pop), 160'({m_if.tdata, m_if.tkeep, m_if.tlast}),
                        160'(exp_beat));
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                q.push_back({rd, rk, rl});
                exp_pkt = exp_pkt + 32'(rl);
                exp_byte = exp_byte + 32'($countones(rk));
            end
            step();
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        s_if.tvalid = 1'b0;
        chk("stream_pops", 160'(n_pop), 160'(100));
        chk("stream_max_level", 160'(max_lvl), 160'(1));
        chk("stream_end_level", 160'(level), 160'(0));
        chk("stream_pkt", 160'(pkt_count), 160'(exp_pkt));
        chk("stream_byte", 160'(byte_count), 160'(exp_byte));

        // Asynchronous reset in the middle of a buffered partial packet
        m_if.tready = 1'b0;
        s_if.tkeep = 16'hFFFF;
        s_if.tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata = 128'(32'h5000 + i);
            step();
        end
        s_if.tvalid = 1'b0;
        chk("pre_rst_level", 160'(level), 160'(5));
        #2 rstn = 1'b0;
        #1;
        chk("arst_mvalid", 160'(m_if.tvalid), 160'(0));
        chk("arst_level", 160'(level), 160'(0));
        chk("arst_sready", 160'(s_if.tready), 160'(0));
        chk("arst_pkt", 160'(pkt_count), 160'(0));
        step();
        step();
        #2 rstn = 1'b1;
        step();
        chk("arel_sready", 160'(s_if.tready), 160'(1));
        m_if.tready = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_if.tvalid) stale++;
            step();
        end
        chk("arel_stale_beats", 160'(stale), 160'(0));
        chk("arel_level", 160'(level), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axis_loopback_fifo.md
AXIS_LOOPBACK_FIFO -- requirements
Module: axis_loopback_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, the stream data width in bits; a multiple of 8.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, the tkeep width.
REQ-003 SHALL have parameter DEPTH, default 16, the FIFO depth in beats; a power of two, at least 2.
REQ-004 SHALL have parameter PTR_WIDTH, default log2(DEPTH), the read/write pointer width.
REQ-005 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port s_axis_tdata  input  DATA_WIDTH  write data from the MM2S DMA read stream.
REQ-008 SHALL have port s_axis_tkeep  input  KEEP_WIDTH  write byte enables.
REQ-009 SHALL have port s_axis_tlast  input  1  end of packet.
REQ-010 SHALL have port s_axis_tvalid  input  1  write beat valid.
REQ-011 SHALL have port s_axis_tready  output  1  FIFO can accept a beat.
REQ-012 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tlast (outputs, DATA_WIDTH/KEEP_WIDTH/1) driving the S2MM DMA write stream.
REQ-013 SHALL have ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1) as the output handshake.
REQ-014 SHALL have port clear  input  1  synchronous clear of the statistics counters.
REQ-015 SHALL have port level  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have port pkt_count  output  32  number of tlast beats delivered on m_axis.
REQ-017 SHALL have port byte_count  output  32  number of bytes delivered on m_axis, counted as the popcount of tkeep.

Function
REQ-018 SHALL accept a beat when s_axis_tvalid && s_axis_tready, and deliver one when m_axis_tvalid && m_axis_tready.
REQ-019 SHALL drive s_axis_tready = (level != DEPTH) from registered state only, with no combinational path from m_axis_tready.
REQ-020 SHALL drive m_axis_tvalid = (level != 0), first-word-fall-through, with m_axis_tdata/tkeep/tlast showing the oldest entry.
REQ-021 SHALL show a beat accepted into an empty FIFO at cycle N on m_axis with tvalid=1 at cycle N+1; there is no same-cycle bypass.
REQ-022 SHALL keep m_axis payload stable while tvalid=1 and tready=0.
REQ-023 SHALL, on a simultaneous accept and deliver, leave level unchanged and advance both pointers.
REQ-024 SHALL, when full, refuse writes (tready=0) even if a read occurs in the same cycle; tready returns to 1 in the cycle after the read.
REQ-025 SHALL wrap the pointers modulo DEPTH; full/empty are derived from a PTR_WIDTH+1 bit occupancy or extra-MSB compare.
REQ-026 SHALL pass tdata, tkeep and tlast unmodified and in order, with no drops and no duplicates.
REQ-027 SHALL increment pkt_count by 1 on each delivered beat with tlast=1, wrapping modulo 2^32.
REQ-028 SHALL add popcount(m_axis_tkeep) (0..KEEP_WIDTH) to byte_count on each delivered beat, wrapping modulo 2^32.
REQ-029 SHALL, when clear=1, set pkt_count and byte_count to 0 at the next edge; clear wins over a same-cycle delivery, whose bytes and packet are not counted.
REQ-030 SHALL leave FIFO contents, pointers and level unaffected by clear.

Reset
REQ-031 SHALL, while rstn=0, force pointers=0, level=0, s_axis_tready=0, m_axis_tvalid=0, pkt_count=0 and byte_count=0; storage contents are don't-care.
REQ-032 SHALL drive s_axis_tready=1 in the first cycle after rstn deasserts.
REQ-033 SHALL, on reset asserted mid-packet, discard all buffered beats immediately; no partial packet is emitted after reset.

Verification
REQ-034 Single beat: push tdata=0x0123..EF, tkeep=0xFFFF, tlast=1 into an empty FIFO -> m_axis_tvalid=1 next cycle with identical payload; after the pop, pkt_count=1, byte_count=16, level=0.
REQ-035 Fill: hold m_axis_tready=0 and push 16 beats -> level=16, s_axis_tready=0; a 17th beat is not accepted; one pop -> tready=1 the cycle after.
REQ-036 Streaming: both sides held ready with 100 random beats -> output order and payload match input, level stays at 1 or less, and throughput after the first beat is 1 beat/cycle.
REQ-037 Partial keep: a 3-beat packet with tkeep 0xFFFF, 0xFFFF, 0x000F -> byte_count=36, pkt_count=1.
REQ-038 Clear collision: assert clear in the same cycle as a tlast delivery -> both counters read 0 next cycle; the FIFO level decrements normally.
REQ-039 Async reset: assert rstn=0 mid-cycle with level=5 -> tvalid=0 and level=0 immediately; after release, tready=1 and no stale beat is emitted.
